pixel_write_sink: RTL and testbench
===================================

// Module: pixel_write_sink
// PURPOSE
//   Receiving end of the pixel-plot stream that drawing blocks produce
//   (x, y, colour, plot strobe, end-of-pass flag). Queues each plotted pixel
//   in a small FIFO and computes its linear framebuffer address (y*WIDTH+x).
//   Writes each queued pixel into the single framebuffer write port whenever
//   the memory arbiter grants it. Discards off-screen pixels and counts them.
//   Signals when a drawing pass has been fully committed to memory.
// PARAMETERS
//   WIDTH       160  screen width in pixels; x_in >= WIDTH is off-screen
//   HEIGHT      120  screen height in pixels; y_in >= HEIGHT is off-screen
//   FIFO_DEPTH  8    pixel queue entries; must be a power of two, >= 2
//   COL_W       3    colour width in bits
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   resetn     in   1      asynchronous, active-low reset
//   plot       in   1      pixel valid; accepted on an edge where plot & ready
//   x_in       in   8      pixel x
//   y_in       in   7      pixel y
//   col_in     in   COL_W  pixel colour
//   flush      in   1      end of drawing pass (source's completed flag); level-sampled
//   ready      out  1      sink can accept a pixel this cycle (= FIFO not full)
//   mem_grant  in   1      framebuffer write port available this cycle
//   mem_wren   out  1      framebuffer write enable
//   mem_addr   out  15     framebuffer word address, y*WIDTH + x
//   mem_data   out  COL_W  framebuffer write data
//   drained    out  1      one-cycle pulse: pass flushed and FIFO empty
//   dropped    out  8      count of off-screen pixels, saturates at 255
// BEHAVIOUR
//   Reset (async): FIFO empty, state IDLE, mem_wren=0, mem_addr=0, mem_data=0,
//     drained=0, dropped=0; ready=1 while and after reset.
//   Accept: plot & ready at an edge. In range -> push {addr, col}. Off-screen ->
//     no push, dropped+1 (holds at 255). Off-screen plots are still gated by ready.
//   Address: y_in*WIDTH + x_in, computed at accept, 15-bit unsigned;
//     max 119*160+159 = 19199. Address arithmetic must not truncate.
//   Write: mem_wren = !empty & mem_grant (combinational); mem_addr/mem_data =
//     FIFO head; head popped on the same edge. mem_addr/mem_data hold the head
//     value (0 when empty) whether or not mem_wren is high.
//   Latency: pixel accepted at edge N with an empty FIFO -> mem_wren high in
//     the cycle after edge N if mem_grant is high. Writes in strict accept order.
//   Simultaneous push & pop: occupancy unchanged. When full, ready=0, so no
//     push. A pop frees one slot; ready rises in the cycle after the pop edge.
//   FSM: IDLE -> ACTIVE on the first accepted plot; IDLE/ACTIVE -> DRAIN on
//     flush=1. In DRAIN, a cycle with FIFO empty and no write -> drained=1 for
//     that cycle, then -> IDLE. Plots are still accepted in DRAIN and extend it.
//     flush with plot in the same cycle: that pixel belongs to the pass.
//     flush in IDLE with empty FIFO: drained pulses in the next cycle.
//     flush held high: re-entering DRAIN after drained is permitted.
//   Reset mid-operation: queued pixels discarded, no further writes issued,
//     no drained pulse generated.
// TESTING
//   1 plot x=5,y=2,col=3, grant=1 -> next cycle mem_wren=1, addr=325, data=3.
//   2 grant=0, push 8 pixels -> ready=0 after 8th; 9th plot held, not accepted;
//     grant=1 -> 8 writes in push order, then 9th accepted and written.
//   3 x=160,y=0 and x=0,y=120 -> no mem_wren, dropped=2; 300 off-screen -> 255.
//   4 grant=0, push 3, flush=1 one cycle, grant=1 -> 3 writes, then drained
//     high exactly one cycle after the last write cycle; state IDLE.
//   5 x=159,y=119 -> addr=19199; x=0,y=0 -> addr=0 (boundary corners).
//   6 5 pixels queued in DRAIN, resetn low -> mem_wren=0 immediately; after
//     release, no writes, drained stays 0, dropped=0, ready=1.

Source files
------------

// File: rtl/pixel_write_sink.sv
// Pixel-plot stream sink: queues on-screen pixels with their linear framebuffer
// address, writes them out on arbiter grant, counts off-screen drops, flags pass completion.
module pixel_write_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int COL_W      = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             plot,
    input  logic [7:0]       x_in,
    input  logic [6:0]       y_in,
    input  logic [COL_W-1:0] col_in,
    input  logic             flush,
    output logic             ready,
    input  logic             mem_grant,
    output logic             mem_wren,
    output logic [14:0]      mem_addr,
    output logic [COL_W-1:0] mem_data,
    output logic             drained,
    output logic [7:0]       dropped
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Widen y before the multiply so the product is formed at full 15 bits.
    function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [14:0] y_wide;
        y_wide = {8'd0, y};
        return (y_wide * 15'(WIDTH)) + {7'd0, x};
    endfunction

    logic [14:0]      addr_q_r [FIFO_DEPTH];
    logic [COL_W-1:0] col_q_r  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [7:0]       dropped_r;
    state_t           state_r;
    state_t           state_s;

    logic empty_s;
    logic full_s;
    logic on_screen_s;
    logic accept_s;
    logic push_s;
    logic pop_s;

    assign empty_s     = (count_r == {(AW+1){1'b0}});
    assign full_s      = (count_r == (AW+1)'(FIFO_DEPTH));
    assign on_screen_s = ({24'd0, x_in} < 32'(WIDTH)) && ({25'd0, y_in} < 32'(HEIGHT));
    assign accept_s    = plot & ~full_s;
    assign push_s      = accept_s & on_screen_s;
    assign pop_s       = ~empty_s & mem_grant;

    assign ready    = ~full_s;
    assign mem_wren = pop_s;
    assign mem_addr = empty_s ? 15'd0 : addr_q_r[rd_ptr_r];
    assign mem_data = empty_s ? {COL_W{1'b0}} : col_q_r[rd_ptr_r];
    // A pixel landing in the empty-queue cycle still belongs to the pass, so it blocks the pulse.
    assign drained  = (state_r == DRAIN) & empty_s & ~push_s;
    assign dropped  = dropped_r;

    // Pixel queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q_r[i] <= 15'd0;
                col_q_r[i]  <= {COL_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                addr_q_r[wr_ptr_r] <= pixel_addr(x_in, y_in);
                col_q_r[wr_ptr_r]  <= col_in;
                wr_ptr_r           <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of off-screen pixels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dropped_r <= 8'd0;
        end else if (accept_s && !on_screen_s && (dropped_r != 8'hFF)) begin
            dropped_r <= dropped_r + 8'd1;
        end
    end

    // Pass-tracking state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Pass-tracking next state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_s = DRAIN;
                end else if (accept_s) begin
                    state_s = ACTIVE;
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (flush) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACTIVE;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_s = flush ? DRAIN : IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: vector table plus scoreboard of
// expected framebuffer writes, with hand sequences for fill, drain and reset.
module tb_pixel_write_sink;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  x_in = 8'd0;
    logic [6:0]  y_in = 7'd0;
    logic [2:0]  col_in = 3'd0;
    logic        flush = 1'b0;
    logic        ready;
    logic        mem_grant = 1'b0;
    logic        mem_wren;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        drained;
    logic [7:0]  dropped;

    pixel_write_sink #(.WIDTH(160), .HEIGHT(120), .FIFO_DEPTH(8), .COL_W(3)) dut (
        .clk(clk), .resetn(resetn), .plot(plot), .x_in(x_in), .y_in(y_in),
        .col_in(col_in), .flush(flush), .ready(ready), .mem_grant(mem_grant),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
        .drained(drained), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  col;
        logic        exp_wr;
        logic [14:0] exp_addr;
    } vec_t;

    vec_t        vecs [8];
    logic [17:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    int          drained_cnt = 0;
    int          model_dropped = 0;
    logic        last_wren, last_drained, last_acc;
    logic [14:0] last_addr;
    logic [2:0]  last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [14:0] model_addr(input int x, input int y);
        return 15'(y * 160 + x);
    endfunction

    // One clock: sample outputs on the falling edge, score writes, record acceptances.
    task automatic cycle();
        logic [17:0] e;
        @(negedge clk);
        last_wren    = mem_wren;
        last_addr    = mem_addr;
        last_data    = mem_data;
        last_drained = drained;
        last_acc     = plot && ready;
        if (drained) drained_cnt++;
        if (mem_wren) begin
            writes++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", mem_addr, mem_data);
            end else begin
                e = sb_q.pop_front();
                if ({mem_addr, mem_data} !== e) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             mem_addr, mem_data, e[17:3], e[2:0]);
                end
            end
        end
        if (last_acc) begin
            if (x_in < 8'd160 && y_in < 7'd120) sb_q.push_back({model_addr(int'(x_in), int'(y_in)), col_in});
            else if (model_dropped < 255) model_dropped++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, d0, acc_at, last_wr_k, dr_k;
        vecs[0] = '{8'd5,   7'd2,   3'd3, 1'b1, 15'd325};
        vecs[1] = '{8'd159, 7'd119, 3'd7, 1'b1, 15'd19199};
        vecs[2] = '{8'd0,   7'd0,   3'd1, 1'b1, 15'd0};
        vecs[3] = '{8'd160, 7'd0,   3'd2, 1'b0, 15'd0};
        vecs[4] = '{8'd0,   7'd120, 3'd4, 1'b0, 15'd0};
        vecs[5] = '{8'd100, 7'd50,  3'd5, 1'b1, 15'd8100};
        vecs[6] = '{8'd255, 7'd127, 3'd6, 1'b0, 15'd0};
        vecs[7] = '{8'd17,  7'd119, 3'd2, 1'b1, 15'd19057};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_drained", drained, 0);
        chk("rst_dropped", dropped, 0);
        resetn = 1'b1;
        cycle();

        // Vector table: single pixels with grant held high
        mem_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            plot = 1'b1; x_in = vecs[i].x; y_in = vecs[i].y; col_in = vecs[i].col;
            cycle();
            plot = 1'b0;
            cycle();
            chk("vec_wren", last_wren, vecs[i].exp_wr);
            if (vecs[i].exp_wr) begin
                chk("vec_addr", last_addr, vecs[i].exp_addr);
                chk("vec_data", last_data, vecs[i].col);
            end
        end
        chk("dropped_after_table", dropped, 3);

        // Fill the queue with grant low, hold a 9th pixel, then release grant
        w0 = writes;
        mem_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            plot = 1'b1; x_in = 8'(i * 10 + 3); y_in = 7'(i * 7); col_in = 3'(i);
            cycle();
            chk("fill_acc", last_acc, 1);
        end
        chk("full_ready", ready, 0);
        x_in = 8'd77; y_in = 7'd33; col_in = 3'd6;
        cycle();
        chk("held_not_acc", last_acc, 0);
        cycle();
        chk("held_not_acc2", last_acc, 0);
        mem_grant = 1'b1;
        acc_at = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (last_acc) begin
                acc_at = k;
                break;
            end
        end
        plot = 1'b0;
        chk("ready_rise_cycle", acc_at, 2);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) cycle();
        cycle();
        chk("fill_writes", writes - w0, 9);
        chk("fill_sb_empty", sb_q.size(), 0);
        chk("ready_after_drain", ready, 1);

        // Flushed pass of 3 pixels: drained one cycle after the last write
        w0 = writes;
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            plot = 1'b1; x_in = 8'(40 + i); y_in = 7'(60 + i); col_in = 3'(i + 1);
            cycle();
        end
        plot = 1'b0; flush = 1'b1;
        cycle();
        chk("flush_cycle_drained", last_drained, 0);
        flush = 1'b0; mem_grant = 1'b1;
        d0 = drained_cnt; last_wr_k = -1; dr_k = -1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (last_wren) last_wr_k = k;
            if (last_drained && dr_k < 0) dr_k = k;
        end
        chk("drain_writes", writes - w0, 3);
        chk("drain_timing", dr_k, last_wr_k + 1);
        chk("drain_pulses", drained_cnt - d0, 1);

        // Flush while idle and empty
        flush = 1'b1;
        cycle();
        chk("idle_flush_early", last_drained, 0);
        flush = 1'b0;
        cycle();
        chk("idle_flush_drained", last_drained, 1);
        cycle();
        chk("idle_flush_single", last_drained, 0);

        // Off-screen saturation
        plot = 1'b1; x_in = 8'd200; y_in = 7'd10; col_in = 3'd1;
        for (int k = 0; k < 300; k++) cycle();
        plot = 1'b0;
        cycle();
        chk("dropped_sat", dropped, 255);

        // Reset in the middle of a drain with 5 queued pixels
        mem_grant = 1'b0; flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            plot = 1'b1; x_in = 8'(i + 1); y_in = 7'(i + 1); col_in = 3'(i + 2);
            cycle();
            flush = 1'b0;
        end
        plot = 1'b0;
        cycle();
        chk("drain_q_no_pulse", last_drained, 0);
        mem_grant = 1'b1; resetn = 1'b0;
        #1;
        chk("midrst_wren", mem_wren, 0);
        sb_q.delete();
        cycle();
        cycle();
        resetn = 1'b1;
        w0 = writes; d0 = drained_cnt;
        for (int k = 0; k < 6; k++) cycle();
        chk("post_rst_writes", writes - w0, 0);
        chk("post_rst_drained", drained_cnt - d0, 0);
        chk("post_rst_dropped", dropped, 0);
        chk("post_rst_ready", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
